// File: rtl/loader_pkg.sv
// Shared types and default constants for the ioctl download loader.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } loaderState_e;

   localparam int         DefSettleCycles = 16;
   localparam logic [7:0] DefRomIndex     = 8'd0;
   localparam logic [7:0] DefModIndex     = 8'd1;
   localparam logic [7:0] DefDipIndex     = 8'd254;
   localparam int         DefMaxMod       = 17;

   localparam logic [16:0] RomBytesMax    = 17'h10000;

endpackage

// File: rtl/ioctl_loader.sv
// Routes ioctl download streams to ROM writes, game select and DIP bytes,
// and holds the game core in reset until a download or user reset has settled.
module ioctl_loader
   import loader_pkg::*;
#(
   parameter int         SETTLE_CYCLES = DefSettleCycles,
   parameter logic [7:0] ROM_INDEX     = DefRomIndex,
   parameter logic [7:0] MOD_INDEX     = DefModIndex,
   parameter logic [7:0] DIP_INDEX     = DefDipIndex,
   parameter int         MAX_MOD       = DefMaxMod
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             user_reset,
   input  logic             ioctl_download,
   input  logic             ioctl_wr,
   input  logic [24:0]      ioctl_addr,
   input  logic [7:0]       ioctl_dout,
   input  logic [7:0]       ioctl_index,
   output logic [15:0]      dn_addr,
   output logic [7:0]       dn_data,
   output logic             dn_wr,
   output logic [4:0]       mod_sel,
   output logic [7:0][7:0]  sw,
   output logic             core_reset,
   output logic [16:0]      rom_bytes,
   output logic             rom_overflow
);

   localparam int          CntW       = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  MaxModByte = 8'(MAX_MOD);

   loaderState_e     state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             dl_q;
   logic             dnWr_q, dnWr_d;
   logic [15:0]      dnAddr_q, dnAddr_d;
   logic [7:0]       dnData_q, dnData_d;
   logic [4:0]       modSel_q, modSel_d;
   logic [7:0][7:0]  sw_q, sw_d;
   logic [16:0]      romBytes_q, romBytes_d;
   logic             romOvf_q, romOvf_d;

   logic             wrOk, romLow, romWr, romOvfWr, modWr, dipWr, romClear;
   logic [16:0]      romBase;

   always_comb begin
      wrOk     = ioctl_wr && ioctl_download;
      romLow   = (ioctl_addr[24:16] == 9'd0);
      romWr    = wrOk && (ioctl_index == ROM_INDEX) && romLow;
      romOvfWr = wrOk && (ioctl_index == ROM_INDEX) && !romLow;
      modWr    = wrOk && (ioctl_index == MOD_INDEX);
      dipWr    = wrOk && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == 22'd0);
      romClear = ioctl_download && !dl_q && (ioctl_index == ROM_INDEX);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (ioctl_download) state_d = LOAD;
         end
         LOAD: begin
            if (!ioctl_download) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            // A new download outranks a user reset; either one restarts the hold.
            if (ioctl_download) begin
               state_d = LOAD;
            end else if (user_reset) begin
               cnt_d = '0;
            end else if (cnt_q == CntLast) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (ioctl_download) begin
               state_d = LOAD;
            end else if (user_reset) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dnWr_d   = romWr;
      dnAddr_d = dnAddr_q;
      dnData_d = dnData_q;
      modSel_d = modSel_q;
      sw_d     = sw_q;
      if (romWr) begin
         dnAddr_d = ioctl_addr[15:0];
         dnData_d = ioctl_dout;
      end
      if (modWr) begin
         modSel_d = (ioctl_dout <= MaxModByte) ? ioctl_dout[4:0] : 5'd0;
      end
      if (dipWr) begin
         sw_d[ioctl_addr[2:0]] = ioctl_dout;
      end
      // The download-start clear applies first so a write in that same cycle still counts.
      romBase    = romClear ? 17'd0 : romBytes_q;
      romBytes_d = romBase;
      if (romWr && (romBase != RomBytesMax)) begin
         romBytes_d = romBase + 17'd1;
      end
      romOvf_d = (romClear ? 1'b0 : romOvf_q) | romOvfWr;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dl_q       <= 1'b0;
         dnWr_q     <= 1'b0;
         dnAddr_q   <= 16'd0;
         dnData_q   <= 8'd0;
         modSel_q   <= 5'd0;
         sw_q       <= {8{8'hFF}};
         romBytes_q <= 17'd0;
         romOvf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dl_q       <= ioctl_download;
         dnWr_q     <= dnWr_d;
         dnAddr_q   <= dnAddr_d;
         dnData_q   <= dnData_d;
         modSel_q   <= modSel_d;
         sw_q       <= sw_d;
         romBytes_q <= romBytes_d;
         romOvf_q   <= romOvf_d;
      end
   end

   assign dn_wr        = dnWr_q;
   assign dn_addr      = dnAddr_q;
   assign dn_data      = dnData_q;
   assign mod_sel      = modSel_q;
   assign sw           = sw_q;
   assign rom_bytes    = romBytes_q;
   assign rom_overflow = romOvf_q;
   assign core_reset   = (state_q != RUN);

endmodule
